// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: who owns the port, what operation
// the latched transaction performs, and the arbiter FSM state encoding.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction fetcher (read-only) and the
// load/store unit. One grant per transaction: the request is latched in IDLE,
// held on the memory bus until mem_resp, and the response is routed back to
// the owner in the same cycle. Data requests have priority unless the fetcher
// has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [31:0]             i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [31:0]             d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_mbe,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31:0]             mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_mbe,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);
  import mem_port_arbiter_pkg::*;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int MBE_W = DATA_WIDTH / 8;

  arb_state_t              state_r, state_next_s;
  arb_op_t                 op_r, op_next_s;
  arb_owner_t              owner_s;
  logic [31:0]             addr_r, addr_next_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_next_s;
  logic [MBE_W-1:0]        mbe_r, mbe_next_s;
  logic [CNT_W-1:0]        starve_cnt_r, starve_cnt_next_s;
  logic                    d_req_s;
  logic                    starve_hit_s;
  logic                    grant_s;

  // Pick the owner for a new grant: D first, unless I has been starved out.
  always_comb begin
    owner_s      = ARB_NONE;
    d_req_s      = d_read | d_write;
    starve_hit_s = (starve_cnt_r == CNT_W'(STARVE_LIMIT));
    if (i_read && (!d_req_s || starve_hit_s)) begin
      owner_s = ARB_I;
    end else if (d_req_s) begin
      owner_s = ARB_D;
    end else begin
      owner_s = ARB_NONE;
    end
  end

  // Next-state logic: latch the winning request in IDLE, hold it until mem_resp.
  always_comb begin
    state_next_s      = state_r;
    op_next_s         = op_r;
    addr_next_s       = addr_r;
    wdata_next_s      = wdata_r;
    mbe_next_s        = mbe_r;
    starve_cnt_next_s = starve_cnt_r;
    case (state_r)
      IDLE: begin
        case (owner_s)
          ARB_I: begin
            state_next_s      = GRANT_I;
            op_next_s         = OP_RD;
            addr_next_s       = i_address;
            wdata_next_s      = {DATA_WIDTH{1'b0}};
            mbe_next_s        = {MBE_W{1'b0}};
            starve_cnt_next_s = {CNT_W{1'b0}};
          end
          ARB_D: begin
            state_next_s = GRANT_D;
            // A simultaneous read and write is treated as a store.
            op_next_s    = d_write ? OP_WR : OP_RD;
            addr_next_s  = d_address;
            wdata_next_s = d_wdata;
            mbe_next_s   = d_mbe;
            if (!i_read) begin
              starve_cnt_next_s = {CNT_W{1'b0}};
            end else if (starve_hit_s) begin
              starve_cnt_next_s = starve_cnt_r;
            end else begin
              starve_cnt_next_s = starve_cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_next_s = IDLE;
            if (!i_read) begin
              starve_cnt_next_s = {CNT_W{1'b0}};
            end else begin
              starve_cnt_next_s = starve_cnt_r;
            end
          end
        endcase
      end
      GRANT_I, GRANT_D: begin
        if (mem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and latched-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      op_r         <= OP_RD;
      addr_r       <= 32'd0;
      wdata_r      <= {DATA_WIDTH{1'b0}};
      mbe_r        <= {MBE_W{1'b0}};
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      op_r         <= op_next_s;
      addr_r       <= addr_next_s;
      wdata_r      <= wdata_next_s;
      mbe_r        <= mbe_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Memory-side outputs come straight from the latched registers.
  always_comb begin
    grant_s     = (state_r != IDLE);
    mem_read    = grant_s && (op_r == OP_RD);
    mem_write   = grant_s && (op_r == OP_WR);
    mem_address = addr_r;
    mem_wdata   = wdata_r;
    mem_mbe     = mbe_r;
  end

  // Route the memory response to the owner only; rdata is zero without resp.
  always_comb begin
    i_resp  = (state_r == GRANT_I) && mem_resp;
    d_resp  = (state_r == GRANT_D) && mem_resp;
    i_rdata = {DATA_WIDTH{1'b0}};
    d_rdata = {DATA_WIDTH{1'b0}};
    if (i_resp) begin
      i_rdata = mem_rdata;
    end else begin
      i_rdata = {DATA_WIDTH{1'b0}};
    end
    if (d_resp) begin
      d_rdata = mem_rdata;
    end else begin
      d_rdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized transactions checked against a transaction-level model of the
// arbitration and starvation rules.
module tb_mem_port_arbiter;

  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [DW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_mbe;
  logic [DW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_mbe;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp;

  int tests = 0;
  int fails = 0;
  int m_cnt = 0;   // model: consecutive D grants while I was waiting

  mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_mbe(d_mbe), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_mbe(mem_mbe), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_address = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'd0;
    d_wdata = 32'd0; d_mbe = 4'd0;
    mem_resp = 1'b0; mem_rdata = 32'd0;
  endtask

  // One transaction starting from IDLE: present the requests, predict the
  // winner from the priority/starvation rules, then run the grant for lat
  // wait cycles plus the response cycle. got reports which resp fired.
  task automatic run_txn(input logic ir, input logic dr, input logic dw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] mbe,
                         input int lat, input logic [31:0] rd,
                         input logic idle_mresp, output int got);
    int          win;
    logic        last;
    logic        exp_wr;
    logic [31:0] exp_addr;
    i_read = ir; i_address = ia;
    d_read = dr; d_write = dw; d_address = da; d_wdata = wd; d_mbe = mbe;
    mem_resp = idle_mresp; mem_rdata = $urandom;
    #1;
    chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
    chk("idle_mem_write", {31'd0, mem_write}, 32'd0);
    chk("idle_i_resp", {31'd0, i_resp}, 32'd0);
    chk("idle_d_resp", {31'd0, d_resp}, 32'd0);
    if (ir && (!(dr || dw) || m_cnt == LIMIT)) win = 1;
    else if (dr || dw) win = 2;
    else win = 0;
    if (win == 1) m_cnt = 0;
    else if (win == 2 && ir) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
    else if (!ir) m_cnt = 0;
    got = 0;
    tick();
    if (win != 0) begin
      exp_addr = (win == 1) ? ia : da;
      exp_wr   = (win == 2) && dw;
      for (int c = 0; c <= lat; c++) begin
        last = (c == lat);
        i_read = 1'($urandom); d_read = 1'($urandom); d_write = 1'($urandom);
        i_address = $urandom; d_address = $urandom; d_wdata = $urandom; d_mbe = 4'($urandom);
        mem_resp = last;
        mem_rdata = last ? rd : 32'($urandom);
        #1;
        chk("mem_read", {31'd0, mem_read}, {31'd0, !exp_wr});
        chk("mem_write", {31'd0, mem_write}, {31'd0, exp_wr});
        chk("mem_address", mem_address, exp_addr);
        if (exp_wr) begin
          chk("mem_wdata", mem_wdata, wd);
          chk("mem_mbe", {28'd0, mem_mbe}, {28'd0, mbe});
        end
        chk("i_resp", {31'd0, i_resp}, {31'd0, (win == 1) && last});
        chk("d_resp", {31'd0, d_resp}, {31'd0, (win == 2) && last});
        chk("i_rdata", i_rdata, ((win == 1) && last) ? rd : 32'd0);
        chk("d_rdata", d_rdata, ((win == 2) && last) ? rd : 32'd0);
        if (last) got = i_resp ? 1 : (d_resp ? 2 : 0);
        tick();
      end
    end
    idle_inputs();
  endtask

  initial begin
    int got;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    tick();
    #1;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_mbe", {28'd0, mem_mbe}, 32'd0);
    chk("rst_i_resp", {31'd0, i_resp}, 32'd0);
    chk("rst_d_resp", {31'd0, d_resp}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rst = 1'b0;
    tick();
    m_cnt = 0;

    // Fetch only, zero-wait memory.
    run_txn(1'b1, 1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 4'h0, 0, 32'h13, 1'b0, got);
    chk("fetch_owner", got, 32'd1);

    // Store with three-cycle memory latency.
    run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 4'b0011, 2, 32'h0, 1'b0, got);
    chk("store_owner", got, 32'd2);

    // Simultaneous requests: D first, then I; stray mem_resp in IDLE ignored.
    run_txn(1'b1, 1'b1, 1'b0, 32'h200, 32'h300, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b1, got);
    chk("simul_first_owner", got, 32'd2);
    run_txn(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 4'h0, 0, 32'h8765_4321, 1'b1, got);
    chk("simul_second_owner", got, 32'd1);

    // Starvation: four D grants, then I is forced.
    for (int k = 0; k < 5; k++) begin
      run_txn(1'b1, 1'b1, 1'b0, 32'h400 + 32'(k * 4), 32'h800 + 32'(k * 4),
              32'h0, 4'h0, k % 2, 32'hC0DE_0000 + 32'(k), 1'b0, got);
      chk("starve_owner", got, (k == 4) ? 32'd1 : 32'd2);
    end

    // Reset in the middle of a data grant.
    d_read = 1'b1; d_address = 32'h500;
    tick();
    d_read = 1'b0;
    #1;
    chk("midrst_grant_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_no_resp", {31'd0, d_resp}, 32'd0);
    tick();
    rst = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("midrst_read_low", {31'd0, mem_read}, 32'd0);
    chk("midrst_write_low", {31'd0, mem_write}, 32'd0);
    chk("midrst_addr", mem_address, 32'd0);
    chk("midrst_d_resp", {31'd0, d_resp}, 32'd0);
    chk("midrst_i_resp", {31'd0, i_resp}, 32'd0);
    tick();
    idle_inputs();
    m_cnt = 0;

    // Held requests with mem_resp always high: resp pulses alternate with IDLE.
    i_read = 1'b1; d_read = 1'b1; mem_resp = 1'b1; mem_rdata = 32'hA5A5_0000;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("hold_resp_pattern", {31'd0, i_resp | d_resp}, {31'd0, (k % 2) == 1});
      chk("hold_resp_exclusive", {31'd0, i_resp & d_resp}, 32'd0);
      tick();
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = 0;

    // Randomized transactions against the model.
    for (int n = 0; n < 300; n++) begin
      run_txn(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              $urandom, $urandom, $urandom, 4'($urandom),
              $urandom_range(0, 3), $urandom, 1'($urandom), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
